// File: rtl/online_digit_streamer.sv
// Digit-serial operand streamer / product collector for the online multiplier core.
// Optional stall watchdog compiled in with STREAMER_TIMEOUT_EN.
module online_digit_streamer #(
  parameter int N_DIGITS       = 8,
  parameter int ONLINE_DELAY   = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                      clk,
  input  logic                                      asyn_reset,
  input  logic                                      start,
  input  logic [2*N_DIGITS-1:0]                     x_word,
  input  logic [2*N_DIGITS-1:0]                     y_word,
  output logic [1:0]                                x_value,
  output logic [1:0]                                y_value,
  output logic                                      data_x_vld,
  input  logic                                      data_x_rdy,
  output logic                                      data_y_vld,
  input  logic                                      data_y_rdy,
  input  logic [1:0]                                p_value,
  input  logic                                      data_out_vld,
  output logic                                      data_out_rdy,
  output logic [2*(N_DIGITS+ONLINE_DELAY)-1:0]      result_word,
  output logic [$clog2(N_DIGITS+ONLINE_DELAY+1)-1:0] digit_index,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      error
);
  localparam int T  = N_DIGITS + ONLINE_DELAY;
  localparam int IW = $clog2(T + 1);

  typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

  state_t                state_q, state_d;
  logic [2*N_DIGITS-1:0] x_lat_q, x_lat_d, y_lat_q, y_lat_d;
  logic                  x_vld_q, x_vld_d, y_vld_q, y_vld_d;
  logic                  x_done_q, x_done_d, y_done_q, y_done_d;
  logic                  out_rdy_q, out_rdy_d;
  logic [1:0]            x_val_q, x_val_d, y_val_q, y_val_d;
  logic [2*T-1:0]        result_q, result_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  hs_x, hs_y, hs_o;
`ifdef STREAMER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  error_q, error_d;
`endif

  // Digit k counts from the MSD; positions past the operand are zero padding for the flush.
  function automatic logic [1:0] sel_digit(input logic [2*N_DIGITS-1:0] w, input logic [IW-1:0] k);
    sel_digit = 2'b00;
    if (int'(k) < N_DIGITS) sel_digit = w[2*(N_DIGITS-1-int'(k)) +: 2];
  endfunction

  assign hs_x = x_vld_q & data_x_rdy;
  assign hs_y = y_vld_q & data_y_rdy;
  assign hs_o = out_rdy_q & data_out_vld;

  always_comb begin
    state_d   = state_q;
    x_lat_d   = x_lat_q;
    y_lat_d   = y_lat_q;
    x_vld_d   = x_vld_q;
    y_vld_d   = y_vld_q;
    x_done_d  = x_done_q;
    y_done_d  = y_done_q;
    out_rdy_d = out_rdy_q;
    x_val_d   = x_val_q;
    y_val_d   = y_val_q;
    result_d  = result_q;
    idx_d     = idx_q;
`ifdef STREAMER_TIMEOUT_EN
    cnt_d     = cnt_q;
    error_d   = error_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        x_lat_d  = x_word;
        y_lat_d  = y_word;
        result_d = '0;
        idx_d    = '0;
        x_vld_d  = 1'b1;
        y_vld_d  = 1'b1;
        x_done_d = 1'b0;
        y_done_d = 1'b0;
        x_val_d  = sel_digit(x_word, '0);
        y_val_d  = sel_digit(y_word, '0);
        state_d  = SEND;
`ifdef STREAMER_TIMEOUT_EN
        cnt_d    = '0;
        error_d  = 1'b0;
`endif
      end
      SEND: begin
        if (hs_x) begin x_vld_d = 1'b0; x_done_d = 1'b1; end
        if (hs_y) begin y_vld_d = 1'b0; y_done_d = 1'b1; end
        if (x_done_d && y_done_d) begin
          x_done_d  = 1'b0;
          y_done_d  = 1'b0;
          out_rdy_d = 1'b1;
          state_d   = RECV;
        end
      end
      RECV: if (hs_o) begin
        result_d  = {result_q[2*T-3:0], p_value};
        idx_d     = idx_q + 1'b1;
        out_rdy_d = 1'b0;
        if (int'(idx_d) == T) begin
          state_d = DONE;
        end else begin
          x_vld_d = 1'b1;
          y_vld_d = 1'b1;
          x_val_d = sel_digit(x_lat_q, idx_d);
          y_val_d = sel_digit(y_lat_q, idx_d);
          state_d = SEND;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef STREAMER_TIMEOUT_EN
    // A handshake on any channel counts as progress and restarts the watchdog.
    if (state_q == SEND || state_q == RECV) begin
      if (hs_x || hs_y || hs_o) begin
        cnt_d = '0;
      end else if (int'(cnt_q) >= TIMEOUT_CYCLES) begin
        cnt_d     = '0;
        x_vld_d   = 1'b0;
        y_vld_d   = 1'b0;
        out_rdy_d = 1'b0;
        x_done_d  = 1'b0;
        y_done_d  = 1'b0;
        error_d   = 1'b1;
        state_d   = DONE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      state_q   <= IDLE;
      x_lat_q   <= '0;
      y_lat_q   <= '0;
      x_vld_q   <= 1'b0;
      y_vld_q   <= 1'b0;
      x_done_q  <= 1'b0;
      y_done_q  <= 1'b0;
      out_rdy_q <= 1'b0;
      x_val_q   <= 2'b00;
      y_val_q   <= 2'b00;
      result_q  <= '0;
      idx_q     <= '0;
`ifdef STREAMER_TIMEOUT_EN
      cnt_q     <= '0;
      error_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      x_lat_q   <= x_lat_d;
      y_lat_q   <= y_lat_d;
      x_vld_q   <= x_vld_d;
      y_vld_q   <= y_vld_d;
      x_done_q  <= x_done_d;
      y_done_q  <= y_done_d;
      out_rdy_q <= out_rdy_d;
      x_val_q   <= x_val_d;
      y_val_q   <= y_val_d;
      result_q  <= result_d;
      idx_q     <= idx_d;
`ifdef STREAMER_TIMEOUT_EN
      cnt_q     <= cnt_d;
      error_q   <= error_d;
`endif
    end
  end

  assign x_value      = x_val_q;
  assign y_value      = y_val_q;
  assign data_x_vld   = x_vld_q;
  assign data_y_vld   = y_vld_q;
  assign data_out_rdy = out_rdy_q;
  assign result_word  = result_q;
  assign digit_index  = idx_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
`ifdef STREAMER_TIMEOUT_EN
  assign error        = error_q;
`else
  assign error        = 1'b0;
`endif
endmodule

// File: doc/online_digit_streamer.md
# online_digit_streamer

Initiator-side driver for the digit-serial online multiplier control. It serializes two parallel operands into 2-bit signed digits, most significant digit first, and offers them on the x/y valid/ready channels. After each digit pair it accepts one 2-bit product digit on the output channel and assembles the full result word. It sits between the host/register interface and the online arithmetic core, and provides the stimulus and collection path that the computation controller expects.

## Interface
- N_DIGITS, 8: digits per operand.
- ONLINE_DELAY, 2: number of extra zero-digit pairs sent after the operands so the core can flush its online delay.
- TIMEOUT_CYCLES, 255: stall limit per handshake. Used only when the timeout feature is compiled in.
- clk  input  1  the block's one clock; all state changes on its rising edge.
- asyn_reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- x_word  input  2*N_DIGITS  operand X; digit i is at [2i+1:2i]; digit N_DIGITS-1 is the MSD.
- y_word  input  2*N_DIGITS  operand Y; same layout as x_word.
- x_value  output  2  current X digit.
- y_value  output  2  current Y digit.
- data_x_vld  output  1  X digit valid.
- data_x_rdy  input  1  core ready for X.
- data_y_vld  output  1  Y digit valid.
- data_y_rdy  input  1  core ready for Y.
- p_value  input  2  product digit from the core.
- data_out_vld  input  1  product digit valid.
- data_out_rdy  output  1  streamer ready for a product digit.
- result_word  output  2*(N_DIGITS+ONLINE_DELAY)  collected product digits; the first digit received ends up as the MSD.
- digit_index  output  $clog2(N_DIGITS+ONLINE_DELAY+1)  number of transaction pairs completed.
- busy  output  1  high in SEND, RECV and DONE.
- done  output  1  one-cycle completion pulse.
- error  output  1  timeout flag. Tied to 0 when the timeout feature is compiled out.

## Operation
- Let T = N_DIGITS+ONLINE_DELAY.
- States: IDLE, SEND, RECV, DONE.
- **IDLE → SEND** on start=1:
  - latch x_word and y_word;
  - clear result_word, digit_index and error;
  - drive data_x_vld=data_y_vld=1 with digit index 0 (the MSD).
- **SEND:**
  - X and Y complete independently, each with its own completion flag.
  - An X handshake is vld&rdy at a rising edge. After it, data_x_vld drops and stays low for the rest of SEND. Y behaves the same way.
  - When both flags are set, clear both flags, go to RECV and set data_out_rdy=1.
  - If both channels handshake on the same edge, the block goes to RECV on that same edge.
- **Digit selection:**
  - For k < N_DIGITS (k = digit_index), x_value is x_word[2(N_DIGITS-1-k)+1 : 2(N_DIGITS-1-k)]; y_value is selected from y_word the same way.
  - For k ≥ N_DIGITS, both digits are 2'b00.
  - Digit values stay stable while the corresponding vld is high.
- **RECV:**
  - On data_out_vld&data_out_rdy, update result_word to {result_word[2T-3:0], p_value}, increment digit_index and drop data_out_rdy.
  - If the new digit_index equals T, go to DONE. Otherwise go to SEND and raise both vld signals with the next digits.
- **DONE:** done=1 for exactly one cycle, then go to IDLE. result_word and digit_index hold until the next start.
- start is ignored in every state except IDLE.
- Digit encoding is passed through as given; the block does no checking and no arithmetic on digits.
- Reset, including reset asserted mid-transfer: state=IDLE. All outputs go to 0: vld, rdy, x_value, y_value, result_word, digit_index, busy, done, error. The latched operands are cleared.

## Timing
- vld, rdy and digit outputs are registered; there are no combinational paths from inputs to outputs.
- If start is sampled at edge E0, data_x_vld and data_y_vld are high from E0.
- With the core always ready, each digit pair takes 2 cycles: handshake at E(2k+1), capture at E(2k+2).
- With no stalls, done is high during the cycle after edge E(2T). The next start is accepted at the earliest at E(2T+1).
- A deasserted rdy or vld extends the corresponding phase one cycle at a time, with no upper bound unless the timeout feature is compiled in.

## Configuration
- **STREAMER_TIMEOUT_EN defined:**
  - A stall counter increments in SEND and RECV and clears on every handshake.
  - When the counter reaches TIMEOUT_CYCLES, on the next edge:
    - all vld and rdy signals drop;
    - error=1;
    - the block goes to DONE, so done pulses and the partial result_word is kept.
  - error holds until the next accepted start or reset.
- **Not defined:** no counter is built, error is constant 0, and the block waits indefinitely.

## Test plan
- Zero-stall run, with N_DIGITS=4, ONLINE_DELAY=2, core always ready, p_value sequence 01,00,11,01,00,01:
  - result_word = 12'b01_00_11_01_00_01;
  - done high exactly 12 cycles after start;
  - digit_index = 6.
- Digit order, with x_word=8'b01_11_00_01 and y_word=8'b11_00_01_01:
  - X digits sent are 01,11,00,01,00,00;
  - Y digits sent are 11,00,01,01,00,00.
- Skewed handshakes: data_y_rdy is held low for 3 cycles while data_x_rdy=1.
  - data_x_vld drops after one cycle.
  - RECV is entered only on the Y handshake edge.
  - x_value is stable throughout.
- Output backpressure: data_out_vld is held low for 5 cycles.
  - data_out_rdy stays high.
  - The capture happens only on the vld edge, and result_word is otherwise unchanged.
- Reset mid-transfer: asyn_reset is pulsed during digit 2.
  - All outputs go to 0 immediately.
  - A following start runs the full sequence cleanly.
- Timeout (STREAMER_TIMEOUT_EN defined, TIMEOUT_CYCLES=10): data_x_rdy is held at 0.
  - After 10 cycles, vld drops and error=1.
  - done pulses once.
  - Without the macro, the block remains in SEND.
